// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller, the
// instruction memory and the PC/fetch blocks.
package imem_ctrl_pkg;

    localparam int IMEM_DEPTH  = 56;
    localparam int IMEM_ADDR_W = 10;
    localparam int IMEM_DATA_W = 32;

    // Instruction handed to decode whenever no valid fetch exists.
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

endpackage

// File: rtl/imem_load_controller.sv
// Arbitrates the single-port instruction memory between the boot-time
// program loader and the CPU fetch path.
//
// Loader handshake: a word is accepted in any cycle where load_valid and
// load_ready are both high; load_ready is high for every LOAD cycle, and the
// accepted word is written to memory on the rising edge that ends that cycle.
//
// load_start has priority in every state: it always restarts the load at
// address 0 and clears load_count, overflow_err and fetch_fault.  An accept
// that coincides with load_start still drives the write strobe, but the
// pointer and count restart from zero, so that word is not counted.
module imem_load_controller
    import imem_ctrl_pkg::*;
#(
    parameter int                 DEPTH    = IMEM_DEPTH,
    parameter int                 ADDR_W   = IMEM_ADDR_W,
    parameter int                 DATA_W   = IMEM_DATA_W,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(imem_ctrl_pkg::NOP_WORD)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              run_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] instruction_out,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] load_count,
    output logic              overflow_err,
    output logic              fetch_fault,
    output logic [1:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_load_count;
    logic              r_overflow_err;
    logic              r_fetch_fault;

    logic              w_accept;
    logic              w_pc_in_range;
    logic              w_fetch_live;

    // Handshake, memory port mux and fetch gating decoded from the state.
    always_comb begin
        w_accept      = (r_state == ST_LOAD) && load_valid;
        w_pc_in_range = (pc_addr < DEPTH_ADDR);
        // A load_start seen in RUN takes the CPU off the memory immediately.
        w_fetch_live  = (r_state == ST_RUN) && !load_start;

        load_ready = (r_state == ST_LOAD);
        cpu_hold   = !w_fetch_live;
        mem_we     = w_accept;
        mem_wdata  = w_accept ? load_data : '0;

        mem_addr = '0;
        if (r_state == ST_LOAD) begin
            mem_addr = r_wptr;
        end else if (r_state == ST_RUN) begin
            mem_addr = pc_addr;
        end

        instruction_out = (w_fetch_live && w_pc_in_range) ? mem_rdata : NOP_WORD;
    end

    // Control FSM with write pointer, word count and the two error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_wptr         <= '0;
            r_load_count   <= '0;
            r_overflow_err <= 1'b0;
            r_fetch_fault  <= 1'b0;
        end else if (load_start) begin
            r_state        <= ST_LOAD;
            r_wptr         <= '0;
            r_load_count   <= '0;
            r_overflow_err <= 1'b0;
            r_fetch_fault  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run_start) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        r_load_count <= r_load_count + ADDR_ONE;
                        // The pointer parks on the last address so mem_addr never leaves the array.
                        if (r_wptr != LAST_ADDR) begin
                            r_wptr <= r_wptr + ADDR_ONE;
                        end
                        if (load_last) begin
                            r_state <= ST_RUN;
                        end else if (r_wptr == LAST_ADDR) begin
                            r_state        <= ST_ERROR;
                            r_overflow_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!w_pc_in_range) begin
                        r_fetch_fault <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    // Only load_start leaves this state; run_start is ignored.
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_count   = r_load_count;
    assign overflow_err = r_overflow_err;
    assign fetch_fault  = r_fetch_fault;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_load_controller.sv
// Bench for imem_load_controller: memory writes go through an expected queue
// checked by an independent monitor; fetches are checked against a program
// image kept by the bench from the words it sent.
module tb_imem_load_controller;

  localparam int DEPTH  = 56;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clock;
  logic              reset;
  logic              load_start;
  logic              run_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [ADDR_W-1:0] pc_addr;
  logic [DATA_W-1:0] instruction_out;
  logic              cpu_hold;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] load_count;
  logic              overflow_err;
  logic              fetch_fault;
  logic [1:0]        dbg_state;

  imem_load_controller dut (
    .clock(clock),
    .reset(reset),
    .load_start(load_start),
    .run_start(run_start),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .pc_addr(pc_addr),
    .instruction_out(instruction_out),
    .cpu_hold(cpu_hold),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .load_count(load_count),
    .overflow_err(overflow_err),
    .fetch_fault(fetch_fault),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- instruction memory (combinational read) ----------------
  logic [DATA_W-1:0] imem [0:DEPTH-1];
  always @(posedge clock) begin
    if (mem_we && mem_addr < ADDR_W'(DEPTH)) imem[mem_addr] <= mem_wdata;
  end
  // Out-of-range reads return a recognisable pattern so missing NOP gating shows up.
  assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? imem[mem_addr] : 32'hDEAD_BEEF;

  // ---------------- counters and reference model ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] prog[$];
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  bit                ref_written [0:DEPTH-1];
  int                m_wptr;
  int                m_count;
  bit                m_fault;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor for memory writes ----------------
  always @(negedge clock) begin
    logic [ADDR_W+DATA_W-1:0] got;
    logic [ADDR_W+DATA_W-1:0] exp;
    if (!reset && mem_we) begin
      got = {mem_addr, mem_wdata};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                   mem_addr, mem_wdata, exp[ADDR_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_load_start();
    load_start = 1'b1;
    next_cycle();
    load_start = 1'b0;
    m_wptr  = 0;
    m_count = 0;
    m_fault = 1'b0;
  endtask

  task automatic pulse_run_start();
    run_start = 1'b1;
    next_cycle();
    run_start = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    exp_q.push_back({ADDR_W'(m_wptr), d});
    ref_mem[m_wptr]     = d;
    ref_written[m_wptr] = 1'b1;
    @(negedge clock);
    check("load_ready", load_ready, 1);
    check("cpu_hold_load", cpu_hold, 1);
    check("instr_nop_load", instruction_out, 0);
    next_cycle();
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    m_count++;
    if (m_wptr < DEPTH - 1) m_wptr++;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    check("load_ready_gap", load_ready, 1);
    check("no_we_gap", mem_we, 0);
    next_cycle();
  endtask

  // gaps: 0 = every cycle, 1 = alternate valid/idle, 2 = random idle cycles
  task automatic load_program(input int gaps, input bit with_last);
    for (int i = 0; i < prog.size(); i++) begin
      if ((gaps == 1 && i > 0) || (gaps == 2 && $urandom_range(0, 1) == 1)) idle_cycle();
      send_word(prog[i], with_last && (i == prog.size() - 1));
    end
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom());
  endtask

  task automatic fetch(input int pc);
    pc_addr = ADDR_W'(pc);
    @(negedge clock);
    if (pc >= DEPTH) check("instr_oob_nop", instruction_out, 0);
    else if (ref_written[pc]) check("instr_fetch", instruction_out, ref_mem[pc]);
    check("mem_addr_run", mem_addr, pc);
    check("cpu_hold_run", cpu_hold, 0);
    check("mem_we_run", mem_we, 0);
    check("fetch_fault", fetch_fault, m_fault);
    next_cycle();
    if (pc >= DEPTH) m_fault = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    load_start = 1'b0;
    run_start  = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    pc_addr    = '0;
    m_wptr     = 0;
    m_count    = 0;
    m_fault    = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_written[i] = 1'b0;

    // Reset values
    @(posedge clock);
    @(negedge clock);
    check("rst_cpu_hold", cpu_hold, 1);
    check("rst_load_ready", load_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_instr", instruction_out, 0);
    check("rst_load_count", load_count, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_fetch_fault", fetch_fault, 0);
    check("rst_state", dbg_state, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Three-word load, valid every cycle
    prog = '{32'h3003_0001, 32'h3004_000C, 32'h8000_0001};
    pulse_load_start();
    load_program(0, 1'b1);
    @(negedge clock);
    check("load3_count", load_count, 3);
    check("load3_hold_falls", cpu_hold, 0);
    check("load3_ready_low", load_ready, 0);
    check("load3_state_run", dbg_state, 2);
    next_cycle();

    // Same load with load_valid toggling
    pulse_load_start();
    load_program(1, 1'b1);
    @(negedge clock);
    check("toggle_count", load_count, 3);
    check("toggle_hold", cpu_hold, 0);
    check("toggle_drained", exp_q.size(), 0);
    next_cycle();

    // Overflow: DEPTH words without load_last
    random_prog(DEPTH);
    pulse_load_start();
    load_program(0, 1'b0);
    @(negedge clock);
    check("ovf_flag", overflow_err, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_ready", load_ready, 0);
    check("ovf_count", load_count, DEPTH);
    check("ovf_state", dbg_state, 3);
    next_cycle();
    pulse_run_start();
    @(negedge clock);
    check("ovf_run_ignored", dbg_state, 3);
    check("ovf_run_hold", cpu_hold, 1);
    next_cycle();
    pulse_load_start();
    @(negedge clock);
    check("ovf_cleared", overflow_err, 0);
    check("ovf_reload_ready", load_ready, 1);
    check("ovf_reload_count", load_count, 0);
    next_cycle();

    // Program for fetch tests, word 5 fixed
    random_prog($urandom_range(8, 20));
    prog[5] = 32'h0C01_000D;
    load_program(2, 1'b1);
    @(negedge clock);
    check("prog_count", load_count, prog.size());
    next_cycle();
    pc_addr = 10'd5;
    @(negedge clock);
    check("fetch5_instr", instruction_out, 32'h0C01_000D);
    check("fetch5_addr", mem_addr, 5);
    next_cycle();
    fetch(60);
    fetch(5);
    fetch(5);
    repeat (40) fetch($urandom_range(0, 63));

    // load_start in RUN: immediate hold and NOP, restart at address 0
    pc_addr    = 10'd5;
    load_start = 1'b1;
    @(negedge clock);
    check("rerun_hold_now", cpu_hold, 1);
    check("rerun_instr_nop", instruction_out, 0);
    check("rerun_no_we", mem_we, 0);
    next_cycle();
    load_start = 1'b0;
    m_wptr  = 0;
    m_count = 0;
    m_fault = 1'b0;
    @(negedge clock);
    check("rerun_fault_clear", fetch_fault, 0);
    check("rerun_state_load", dbg_state, 1);
    next_cycle();
    send_word($urandom(), 1'b0);
    send_word($urandom(), 1'b0);

    // Asynchronous reset mid-load
    #2;
    reset = 1'b1;
    #1;
    check("arst_hold", cpu_hold, 1);
    check("arst_ready", load_ready, 0);
    check("arst_we", mem_we, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_count", load_count, 0);
    check("arst_instr", instruction_out, 0);
    check("arst_state", dbg_state, 0);
    next_cycle();
    reset = 1'b0;
    m_wptr  = 0;
    m_count = 0;
    next_cycle();
    pc_addr = 10'd0;
    pulse_run_start();
    @(negedge clock);
    check("arst_run_state", dbg_state, 2);
    check("arst_run_count", load_count, 0);
    check("arst_run_hold", cpu_hold, 0);
    next_cycle();

    // Randomised loads and fetches
    repeat (4) begin
      pulse_load_start();
      random_prog($urandom_range(1, 30));
      load_program(2, 1'b1);
      @(negedge clock);
      check("rand_count", load_count, m_count);
      check("rand_state_run", dbg_state, 2);
      next_cycle();
      repeat (10) fetch($urandom_range(0, 63));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
